note_event_capture: RTL and testbench

//  Parametrised keyboard front end: encodes one-hot note/length keys, tracks a saturating octave

---
 rtl/note_event_capture_pkg.sv | 33 +++
 rtl/note_event_capture_if.sv | 15 +
 rtl/note_event_capture_sync_fifo.sv | 47 ++++
 rtl/note_event_capture.sv | 148 ++++++++++++++
 tb/tb_note_event_capture.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/note_event_capture_pkg.sv
// Shared widths, codes and event layout for the keyboard capture front end.
// Combinational definitions only; no latency, no backpressure.
package note_event_capture_pkg;
  localparam int NOTE_KEYS        = 7;
  localparam int LENGTH_KEYS      = 7;
  localparam int OCTAVE_BITS      = 3;
  localparam int CLOCK_BITS       = 32;
  localparam int NOTE_BITS        = $clog2(NOTE_KEYS + 1);
  localparam int LENGTH_BITS      = $clog2(LENGTH_KEYS);
  localparam int OCT_MIN          = 1;
  localparam int OCT_MAX          = 5;
  localparam int DEF_FIFO_DEPTH   = 8;

  localparam logic [NOTE_BITS-1:0] REST = NOTE_BITS'(NOTE_KEYS);

  typedef struct packed {
    logic [CLOCK_BITS-1:0]  ev_time;
    logic [OCTAVE_BITS-1:0] ev_octave;
    logic [NOTE_BITS-1:0]   ev_note;
    logic [LENGTH_BITS-1:0] ev_length;
  } ev_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sess_state_t;

  function automatic logic [OCTAVE_BITS-1:0] clamp_octave(input logic [OCTAVE_BITS-1:0] oct);
    if (oct < OCTAVE_BITS'(OCT_MIN)) return OCTAVE_BITS'(OCT_MIN);
    if (oct > OCTAVE_BITS'(OCT_MAX)) return OCTAVE_BITS'(OCT_MAX);
    return oct;
  endfunction
endpackage

// File: rtl/note_event_capture_if.sv
// Event stream from the capture block to the recorder: head payload plus valid/ready.
// Head is held stable while ev_valid is high and ev_ready is low.
interface note_event_capture_if;
  import note_event_capture_pkg::*;

  logic                   ev_valid;
  logic                   ev_ready;
  logic [CLOCK_BITS-1:0]  ev_time;
  logic [OCTAVE_BITS-1:0] ev_octave;
  logic [NOTE_BITS-1:0]   ev_note;
  logic [LENGTH_BITS-1:0] ev_length;

  modport master (output ev_valid, ev_time, ev_octave, ev_note, ev_length, input ev_ready);
  modport slave  (input ev_valid, ev_time, ev_octave, ev_note, ev_length, output ev_ready);
endinterface

// File: rtl/note_event_capture_sync_fifo.sv
// Synchronous FIFO with flush; a push lands in the head one cycle later (valid next cycle).
// Push on full is accepted only together with a pop; otherwise the caller sees o_full.
module note_event_capture_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_rst && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/note_event_capture.sv
// Encodes note/length keys, tracks octave, timestamps note changes into an event FIFO.
// Event valid one cycle after the sampling edge; events on a full FIFO without a pop are dropped.
module note_event_capture
  import note_event_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [OCTAVE_BITS-1:0] i_octave_in,
  input  logic                   i_oct_up,
  input  logic                   i_oct_down,
  input  logic [NOTE_KEYS-1:0]   i_note_key,
  input  logic [LENGTH_KEYS-1:0] i_length_key,
  input  logic [CLOCK_BITS-1:0]  i_system_clock,
  output logic [OCTAVE_BITS-1:0] o_octave,
  output logic [NOTE_BITS-1:0]   o_note,
  output logic [LENGTH_BITS-1:0] o_length,
  output logic                   o_overflow,
  output logic                   o_key_error,
  note_event_capture_if.master   ev
);
  sess_state_t            r_state, w_state_nxt;
  logic                   w_first, w_run;
  logic [OCTAVE_BITS-1:0] r_octave;
  logic [NOTE_BITS-1:0]   r_note, w_note_enc, w_note_idx;
  logic [LENGTH_BITS-1:0] r_length, w_length_enc, w_length_idx;
  logic [3:0]             w_note_cnt, w_length_cnt;
  logic [CLOCK_BITS-1:0]  r_start;
  logic                   r_up_d, r_dn_d, r_overflow, r_key_error;
  logic                   w_up_edge, w_dn_edge, w_multi;
  logic                   w_push, w_pop, w_full, w_empty;
  ev_t                    w_push_dat, w_head_dat;

  always_comb begin
    w_note_cnt   = '0;
    w_note_idx   = '0;
    w_length_cnt = '0;
    w_length_idx = '0;
    for (int i = 0; i < NOTE_KEYS; i++) begin
      if (i_note_key[i]) begin
        w_note_cnt = w_note_cnt + 4'd1;
        w_note_idx = NOTE_BITS'(i);
      end
    end
    for (int i = 0; i < LENGTH_KEYS; i++) begin
      if (i_length_key[i]) begin
        w_length_cnt = w_length_cnt + 4'd1;
        w_length_idx = LENGTH_BITS'(i);
      end
    end
    // Multi-hot holds the previous code; a released length key also holds.
    w_note_enc   = (w_note_cnt == 4'd0) ? REST :
                   (w_note_cnt == 4'd1) ? w_note_idx : r_note;
    w_length_enc = (w_length_cnt == 4'd1) ? w_length_idx : r_length;
  end

  assign w_multi   = (w_note_cnt > 4'd1) || (w_length_cnt > 4'd1);
  assign w_up_edge = i_oct_up && !r_up_d;
  assign w_dn_edge = i_oct_down && !r_dn_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: if (i_en) begin
        w_state_nxt = ST_RUN;
        w_first     = 1'b1;
      end
      ST_RUN: begin
        if (!i_en) w_state_nxt = ST_IDLE;
        else       w_run       = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_push     = w_run && (w_note_enc != r_note);
  assign w_pop      = !w_empty && ev.ev_ready;
  assign w_push_dat = '{ev_time:   i_system_clock - r_start,
                        ev_octave: r_octave,
                        ev_note:   w_note_enc,
                        ev_length: r_length};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_octave    <= OCTAVE_BITS'(OCT_MIN);
      r_note      <= REST;
      r_length    <= '0;
      r_start     <= '0;
      r_up_d      <= 1'b0;
      r_dn_d      <= 1'b0;
      r_overflow  <= 1'b0;
      r_key_error <= 1'b0;
    end else begin
      r_up_d   <= i_oct_up;
      r_dn_d   <= i_oct_down;
      r_length <= w_length_enc;
      if (w_multi) r_key_error <= 1'b1;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_first) r_start <= i_system_clock;
      if (!i_en) begin
        r_octave <= clamp_octave(i_octave_in);
        r_note   <= REST;
      end else begin
        r_note <= w_note_enc;
        if (w_up_edge && !w_dn_edge && r_octave < OCTAVE_BITS'(OCT_MAX))
          r_octave <= r_octave + OCTAVE_BITS'(1);
        else if (w_dn_edge && !w_up_edge && r_octave > OCTAVE_BITS'(OCT_MIN))
          r_octave <= r_octave - OCTAVE_BITS'(1);
      end
    end
  end

  note_event_capture_sync_fifo #(
    .WIDTH ($bits(ev_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_flush    (!i_en),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head_dat),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign ev.ev_valid  = !w_empty;
  assign ev.ev_time   = w_head_dat.ev_time;
  assign ev.ev_octave = w_head_dat.ev_octave;
  assign ev.ev_note   = w_head_dat.ev_note;
  assign ev.ev_length = w_head_dat.ev_length;

  assign o_octave    = r_octave;
  assign o_note      = r_note;
  assign o_length    = r_length;
  assign o_overflow  = r_overflow;
  assign o_key_error = r_key_error;
endmodule

// File: tb/tb_note_event_capture.sv
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_note_event_capture;
  import note_event_capture_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, oct_up, oct_down;
  logic [2:0]  octave_in;
  logic [6:0]  note_key, length_key;
  logic [31:0] sysclk;
  logic [2:0]  o_octave, o_note, o_length;
  logic        o_overflow, o_key_error;

  note_event_capture_if u_if();

  note_event_capture dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_octave_in(octave_in),
    .i_oct_up(oct_up), .i_oct_down(oct_down), .i_note_key(note_key),
    .i_length_key(length_key), .i_system_clock(sysclk),
    .o_octave(o_octave), .o_note(o_note), .o_length(o_length),
    .o_overflow(o_overflow), .o_key_error(o_key_error), .ev(u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] t;
    int          oct;
    int          note;
    int          len;
  } exp_ev_t;

  exp_ev_t     m_q[$];
  int          m_oct, m_note, m_len;
  logic [31:0] m_start;
  bit          m_active, m_up_prev, m_dn_prev, m_ovf, m_kerr;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [6:0] k);
    for (int i = 0; i < 7; i++) if (k[i]) return i;
    return -1;
  endfunction

  // Applies the effect of the coming clock edge, using the inputs currently driven.
  task automatic model_step();
    int      ncnt, lcnt, new_note, new_len;
    bit      up_e, dn_e;
    exp_ev_t e;
    if (rst) begin
      m_q.delete();
      m_oct = 1; m_note = 7; m_len = 0; m_start = '0;
      m_active = 0; m_up_prev = 0; m_dn_prev = 0; m_ovf = 0; m_kerr = 0;
      return;
    end
    ncnt = $countones(note_key);
    lcnt = $countones(length_key);
    if (ncnt > 1 || lcnt > 1) m_kerr = 1;
    new_note = (ncnt == 0) ? 7 : (ncnt == 1) ? onehot_idx(note_key) : m_note;
    new_len  = (lcnt == 1) ? onehot_idx(length_key) : m_len;
    up_e = oct_up && !m_up_prev;
    dn_e = oct_down && !m_dn_prev;
    if (!en) begin
      m_q.delete();
      m_oct    = (octave_in < 1) ? 1 : (octave_in > 5) ? 5 : int'(octave_in);
      m_note   = 7;
      m_active = 0;
    end else begin
      if (u_if.ev_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (!m_active) begin
        m_start  = sysclk;
        m_active = 1;
      end else if (new_note != m_note) begin
        e.t = sysclk - m_start; e.oct = m_oct; e.note = new_note; e.len = m_len;
        if (m_q.size() < 8) m_q.push_back(e);
        else m_ovf = 1;
      end
      if (up_e && !dn_e && m_oct < 5) m_oct++;
      else if (dn_e && !up_e && m_oct > 1) m_oct--;
      m_note = new_note;
    end
    m_len     = new_len;
    m_up_prev = oct_up;
    m_dn_prev = oct_down;
  endtask

  task automatic check_all();
    check("octave", o_octave, m_oct);
    check("note", o_note, m_note);
    check("length", o_length, m_len);
    check("ev_valid", u_if.ev_valid, m_q.size() != 0);
    check("overflow", o_overflow, m_ovf);
    check("key_error", o_key_error, m_kerr);
    if (m_q.size() != 0) begin
      check("ev_time", u_if.ev_time, m_q[0].t);
      check("ev_octave", u_if.ev_octave, m_q[0].oct);
      check("ev_note", u_if.ev_note, m_q[0].note);
      check("ev_length", u_if.ev_length, m_q[0].len);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [31:0] t3_start;
    logic [31:0] t4_clk[9];
    int          r;

    rst = 1; en = 0; octave_in = 3'd1; oct_up = 0; oct_down = 0;
    note_key = '0; length_key = '0; sysclk = 32'd0; u_if.ev_ready = 0;
    tick(); tick();
    check("rst_octave", o_octave, 1);
    check("rst_note", o_note, 7);
    check("rst_valid", u_if.ev_valid, 0);
    rst = 0;
    tick();

    // Session start at 100, key 2 pressed at 130
    en = 1; sysclk = 32'd100; tick();
    check("first_edge_no_event", u_if.ev_valid, 0);
    sysclk = 32'd110; tick();
    sysclk = 32'd120; tick();
    note_key = 7'b0000100; sysclk = 32'd130; tick();
    check("t1_valid", u_if.ev_valid, 1);
    check("t1_time", u_if.ev_time, 30);
    check("t1_note", u_if.ev_note, 2);
    check("t1_oct", u_if.ev_octave, 1);

    // Release to rest, then multi-hot
    note_key = '0; sysclk = 32'd140; tick();
    note_key = 7'b0001010; sysclk = 32'd150; tick();
    check("t2_key_error", o_key_error, 1);
    check("t2_note_held", o_note, 7);
    u_if.ev_ready = 1; note_key = '0; tick();
    check("t2_rest_time", u_if.ev_time, 40);
    check("t2_rest_note", u_if.ev_note, 7);
    tick();
    check("t2_drained", u_if.ev_valid, 0);

    // Octave buttons
    en = 0; octave_in = 3'd4; tick();
    en = 1; sysclk = 32'd1000; t3_start = sysclk; tick();
    oct_up = 1;
    for (int i = 0; i < 10; i++) begin sysclk += 1; tick(); end
    check("t3_up_once", o_octave, 5);
    oct_up = 0; tick();
    oct_up = 1; tick(); tick();
    check("t3_saturate", o_octave, 5);
    oct_up = 0; tick();
    oct_up = 1; oct_down = 1; tick();
    check("t3_up_down", o_octave, 5);
    oct_up = 0; oct_down = 0; tick();
    oct_down = 1; tick();
    check("t3_down", o_octave, 4);
    oct_down = 0; tick();

    // Fill beyond depth with the consumer stalled
    u_if.ev_ready = 0;
    for (int i = 0; i < 9; i++) begin
      note_key = 7'b1 << (i % 7);
      sysclk += 32'd10;
      t4_clk[i] = sysclk;
      tick();
    end
    check("t4_overflow", o_overflow, 1);
    u_if.ev_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("t4_order_valid", u_if.ev_valid, 1);
      check("t4_order_note", u_if.ev_note, i % 7);
      check("t4_order_time", u_if.ev_time, t4_clk[i] - t3_start);
      tick();
    end
    check("t4_empty", u_if.ev_valid, 0);

    // Timestamp wrap
    en = 0; note_key = '0; tick();
    en = 1; sysclk = 32'hFFFF_FFF0; tick();
    u_if.ev_ready = 0; sysclk = 32'h10; note_key = 7'b0010000; tick();
    check("t5_wrap_time", u_if.ev_time, 32'h20);
    u_if.ev_ready = 1; tick();

    // Reset with events queued
    u_if.ev_ready = 0;
    for (int i = 0; i < 3; i++) begin
      note_key = 7'b1 << i; sysclk += 32'd5; tick();
    end
    check("t6_queued", u_if.ev_valid, 1);
    rst = 1; tick();
    check("t6_valid", u_if.ev_valid, 0);
    check("t6_octave", o_octave, 1);
    check("t6_note", o_note, 7);
    check("t6_overflow", o_overflow, 0);
    rst = 0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 19) != 0);
      octave_in = 3'($urandom_range(0, 7));
      oct_up    = ($urandom_range(0, 3) == 0);
      oct_down  = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r < 3)      note_key = '0;
      else if (r < 9) note_key = 7'b1 << $urandom_range(0, 6);
      else            note_key = 7'($urandom);
      r = $urandom_range(0, 9);
      if (r < 3)      length_key = '0;
      else if (r < 9) length_key = 7'b1 << $urandom_range(0, 6);
      else            length_key = 7'($urandom);
      u_if.ev_ready = ($urandom_range(0, 2) == 0);
      sysclk += 32'($urandom_range(1, 20));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
